// File: rtl/m_sram_ctl_if.sv
// Bus bundle between the J1A Wishbone master, the cellular-RAM controller and the RAM pads.
// The controller uses the slave modport; the CPU side uses the master modport.
interface m_sram_ctl_if #(
  parameter int ADR_W = 23
);
  logic [ADR_W-1:0] wb_adr_i;
  logic [15:0]      wb_dat_i;
  logic [15:0]      wb_dat_o;
  logic [1:0]       wb_sel_i;
  logic             wb_we_i;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_ack_o;
  logic [ADR_W-1:0] sram_adr_o;
  logic [15:0]      sram_dat_i;
  logic [15:0]      sram_dat_o;
  logic             sram_dat_oe_o;
  logic             sram_ce_n_o;
  logic             sram_oe_n_o;
  logic             sram_we_n_o;
  logic             sram_lb_n_o;
  logic             sram_ub_n_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, sram_dat_i,
    output wb_dat_o, wb_ack_o, sram_adr_o, sram_dat_o, sram_dat_oe_o,
    output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/m_sram_ctl.sv
// Wishbone classic slave driving the Nexys2 Micron cellular RAM in asynchronous mode.
// Optional same-page fast reads are enabled by defining SRAM_PAGE_EN.
module m_sram_ctl #(
  parameter int ADR_W   = 23,
  parameter int RD_WAIT = 4,
  parameter int WR_WAIT = 4,
  parameter int TURN    = 1
`ifdef SRAM_PAGE_EN
  , parameter int PAGE_WAIT = 1
`endif
) (
  input logic          sys_clk_i,
  input logic          sys_res_i,
  m_sram_ctl_if.slave  bus
);

  localparam int MAX_RW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
`ifdef SRAM_PAGE_EN
  localparam int MAX_ACC = (PAGE_WAIT > MAX_RW) ? PAGE_WAIT : MAX_RW;
`else
  localparam int MAX_ACC = MAX_RW;
`endif
  // The recovery phase reuses the wait counter, so it must also hold TURN.
  localparam int MAX_CNT = (TURN > MAX_ACC) ? TURN : MAX_ACC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_WR    = 3'd2;
  localparam logic [2:0] ST_WHOLD = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_RECOV = 3'd5;
`ifdef SRAM_PAGE_EN
  localparam logic [2:0] ST_PAGE  = 3'd6;
`endif

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ADR_W-1:0] adr_r;
  logic [15:0]      wr_dat_r;
  logic [15:0]      rd_dat_r;
  logic             ack_r;
  logic             ce_n_r;
  logic             oe_n_r;
  logic             we_n_r;
  logic             lb_n_r;
  logic             ub_n_r;
  logic             dat_oe_r;
  logic             abort_r;
  logic             req_s;
  logic             page_keep_s;
  logic             page_hit_s;

  assign req_s = bus.wb_cyc_i & bus.wb_stb_i;

  // Page-mode qualifiers: keep the RAM open after a completed read, and detect a same-page follow-up read.
  always_comb begin
    page_keep_s = 1'b0;
    page_hit_s  = 1'b0;
`ifdef SRAM_PAGE_EN
    page_keep_s = ~abort_r & bus.wb_cyc_i;
    page_hit_s  = req_s & ~bus.wb_we_i &
                  (bus.wb_adr_i[ADR_W-1:4] == adr_r[ADR_W-1:4]);
`endif
  end

  // Transaction sequencer; every RAM strobe and bus output is a flop.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_res_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      adr_r    <= '0;
      wr_dat_r <= 16'h0000;
      rd_dat_r <= 16'h0000;
      ack_r    <= 1'b0;
      ce_n_r   <= 1'b1;
      oe_n_r   <= 1'b1;
      we_n_r   <= 1'b1;
      lb_n_r   <= 1'b1;
      ub_n_r   <= 1'b1;
      dat_oe_r <= 1'b0;
      abort_r  <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            adr_r    <= bus.wb_adr_i;
            wr_dat_r <= bus.wb_dat_i;
            ce_n_r   <= 1'b0;
            lb_n_r   <= ~bus.wb_sel_i[0];
            ub_n_r   <= ~bus.wb_sel_i[1];
            abort_r  <= 1'b0;
            if (bus.wb_we_i) begin
              state_r  <= ST_WR;
              we_n_r   <= 1'b0;
              dat_oe_r <= 1'b1;
              cnt_r    <= CNT_W'(WR_WAIT);
            end else begin
              state_r <= ST_RD;
              oe_n_r  <= 1'b0;
              cnt_r   <= CNT_W'(RD_WAIT);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (!bus.wb_cyc_i) begin
            abort_r <= 1'b1;
          end
          if (cnt_r == CNT_ONE) begin
            rd_dat_r <= bus.sram_dat_i;
            ack_r    <= ~abort_r & bus.wb_cyc_i;
            state_r  <= ST_ACK;
            if (!page_keep_s) begin
              ce_n_r <= 1'b1;
              oe_n_r <= 1'b1;
              lb_n_r <= 1'b1;
              ub_n_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WR: begin
          if (!bus.wb_cyc_i) begin
            abort_r <= 1'b1;
          end
          if (cnt_r == CNT_ONE) begin
            we_n_r  <= 1'b1;
            state_r <= ST_WHOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WHOLD: begin
          ack_r    <= ~abort_r & bus.wb_cyc_i;
          ce_n_r   <= 1'b1;
          lb_n_r   <= 1'b1;
          ub_n_r   <= 1'b1;
          dat_oe_r <= 1'b0;
          state_r  <= ST_ACK;
        end
        ST_ACK: begin
          cnt_r   <= CNT_W'(TURN);
          state_r <= ST_RECOV;
`ifdef SRAM_PAGE_EN
          // OE# still low here means the read left the page open.
          if (!oe_n_r) begin
            state_r <= ST_PAGE;
          end
`endif
        end
`ifdef SRAM_PAGE_EN
        ST_PAGE: begin
          if (page_hit_s) begin
            adr_r   <= bus.wb_adr_i;
            lb_n_r  <= ~bus.wb_sel_i[0];
            ub_n_r  <= ~bus.wb_sel_i[1];
            abort_r <= 1'b0;
            cnt_r   <= CNT_W'(PAGE_WAIT);
            state_r <= ST_RD;
          end else begin
            ce_n_r  <= 1'b1;
            oe_n_r  <= 1'b1;
            lb_n_r  <= 1'b1;
            ub_n_r  <= 1'b1;
            cnt_r   <= CNT_W'(TURN);
            state_r <= ST_RECOV;
          end
        end
`endif
        ST_RECOV: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ce_n_r   <= 1'b1;
          oe_n_r   <= 1'b1;
          we_n_r   <= 1'b1;
          lb_n_r   <= 1'b1;
          ub_n_r   <= 1'b1;
          dat_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_dat_o      = rd_dat_r;
  assign bus.wb_ack_o      = ack_r;
  assign bus.sram_adr_o    = adr_r;
  assign bus.sram_dat_o    = wr_dat_r;
  assign bus.sram_dat_oe_o = dat_oe_r;
  assign bus.sram_ce_n_o   = ce_n_r;
  assign bus.sram_oe_n_o   = oe_n_r;
  assign bus.sram_we_n_o   = we_n_r;
  assign bus.sram_lb_n_o   = lb_n_r;
  assign bus.sram_ub_n_o   = ub_n_r;

endmodule

// File: tb/tb_m_sram_ctl.sv
// Directed bench for m_sram_ctl with a 64-word byte-lane RAM model.
// Expectations follow SRAM_PAGE_EN when it is defined for the build.
module tb_m_sram_ctl;
  localparam int ADR_W = 23;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  m_sram_ctl_if #(.ADR_W(ADR_W)) bus();

  m_sram_ctl #(
    .ADR_W(ADR_W), .RD_WAIT(4), .WR_WAIT(4), .TURN(1)
`ifdef SRAM_PAGE_EN
    , .PAGE_WAIT(1)
`endif
  ) dut (
    .sys_clk_i(clk),
    .sys_res_i(res_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] mem [0:63];

  function automatic logic [15:0] init_val(input logic [5:0] a);
    case (a)
      6'h10:   init_val = 16'hBEEF;
      6'h20:   init_val = 16'hA5C3;
      6'h21:   init_val = 16'h9ABC;
      6'h22:   init_val = 16'h0F0F;
      6'h3F:   init_val = 16'hC0DE;
      default: init_val = {10'b0101101000, a};
    endcase
  endfunction

  assign bus.sram_dat_i = (!bus.sram_ce_n_o && !bus.sram_oe_n_o) ? mem[bus.sram_adr_o[5:0]] : 16'h0000;

  // RAM latches the enabled byte lanes on the rising edge of WE#.
  always @(posedge bus.sram_we_n_o) begin
    if (!bus.sram_ce_n_o && bus.sram_dat_oe_o) begin
      if (!bus.sram_ub_n_o) mem[bus.sram_adr_o[5:0]][15:8] <= bus.sram_dat_o[15:8];
      if (!bus.sram_lb_n_o) mem[bus.sram_adr_o[5:0]][7:0]  <= bus.sram_dat_o[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [22:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic [15:0] exp_rd;
    int          exp_lat;
    logic        exp_lb_n;
    logic        exp_ub_n;
  } vec_t;

  vec_t vecs [10];

  task automatic xfer(input vec_t v, input int idx);
    int lat, acks, ce_lo, oe_lo, we_lo, doe_hi;
    logic [15:0] rd;
    logic lb_n, ub_n, oe_ack;
    string t;
    t = $sformatf("v%0d", idx);
    lat = -1; acks = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; doe_hi = 0;
    rd = 16'h0000; oe_ack = 1'b0;
    bus.wb_adr_i = v.adr; bus.wb_dat_i = v.dat; bus.wb_sel_i = v.sel;
    bus.wb_we_i = v.we; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    lb_n = bus.sram_lb_n_o;
    ub_n = bus.sram_ub_n_o;
    for (int n = 0; n <= 24; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (bus.wb_ack_o) begin
        acks++;
        if (lat < 0) begin
          lat = n; rd = bus.wb_dat_o; oe_ack = bus.sram_oe_n_o;
          bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        end
      end else if (lat < 0) begin
        if (!bus.sram_ce_n_o) ce_lo++;
        if (!bus.sram_oe_n_o) oe_lo++;
        if (!bus.sram_we_n_o) we_lo++;
        if (bus.sram_dat_oe_o) doe_hi++;
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    chk({t, " latency"}, lat, v.exp_lat);
    chk({t, " ack count"}, acks, 1);
    chk({t, " lb_n/ub_n"}, {lb_n, ub_n}, {v.exp_lb_n, v.exp_ub_n});
    chk({t, " ce_n low cycles"}, ce_lo, v.exp_lat);
    if (!v.we) begin
      chk({t, " read data"}, rd, v.exp_rd);
      chk({t, " oe_n low cycles"}, oe_lo, 4);
      chk({t, " dat_oe on read"}, doe_hi, 0);
`ifndef SRAM_PAGE_EN
      chk({t, " oe_n at ack"}, oe_ack, 1'b1);
`endif
    end else begin
      chk({t, " we_n low cycles"}, we_lo, 4);
      chk({t, " dat_oe cycles"}, doe_hi, 5);
      chk({t, " oe_n low on write"}, oe_lo, 0);
    end
  endtask

  // Reads with stb held; each ack advances the address, gaps counted in ack-low cycles.
  task automatic b2b(input logic [22:0] base, input int cnt, input int exp_gap, input string t);
    int k, last;
    logic [22:0] a;
    k = 0; last = -1; a = base;
    bus.wb_adr_i = base; bus.wb_we_i = 1'b0; bus.wb_sel_i = 2'b11;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (int n = 0; n < 200 && k < cnt; n++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) begin
        chk($sformatf("%s data%0d", t, k), bus.wb_dat_o, init_val(a[5:0]));
        if (k > 0) chk($sformatf("%s gap%0d", t, k), n - last - 1, exp_gap);
        last = n; k++; a = a + 23'd1;
        bus.wb_adr_i = a;
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    chk({t, " ack total"}, k, cnt);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int acks, oe_lo;
    vec_t rv;
    for (int i = 0; i < 64; i++) mem[i] <= init_val(i[5:0]);
    bus.wb_adr_i = '0; bus.wb_dat_i = 16'h0000; bus.wb_sel_i = 2'b00;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;

    vecs[0] = '{1'b0, 23'h10, 16'h0000, 2'b11, 16'hBEEF, 4, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 23'h20, 16'h1234, 2'b10, 16'h0000, 5, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 23'h20, 16'h0000, 2'b11, 16'h12C3, 4, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 23'h21, 16'h5678, 2'b01, 16'h0000, 5, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 23'h21, 16'h0000, 2'b11, 16'h9A78, 4, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 23'h22, 16'hFFFF, 2'b00, 16'h0000, 5, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 23'h22, 16'h0000, 2'b11, 16'h0F0F, 4, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 23'h3F, 16'h0000, 2'b11, 16'hC0DE, 4, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 23'h23, 16'hCAFE, 2'b11, 16'h0000, 5, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 23'h23, 16'h0000, 2'b11, 16'hCAFE, 4, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", bus.wb_ack_o, 1'b0);
    chk("reset strobes", {bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o,
                          bus.sram_lb_n_o, bus.sram_ub_n_o}, 5'b11111);
    chk("reset dat_oe", bus.sram_dat_oe_o, 1'b0);
    chk("reset wb_dat_o", bus.wb_dat_o, 16'h0000);
    chk("reset sram_adr_o", bus.sram_adr_o, 23'h0);
    res_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) xfer(vecs[i], i);

`ifdef SRAM_PAGE_EN
    b2b(23'h00, 4, 2, "b2b 0..3");
    b2b(23'h0F, 2, 7, "b2b page cross");
`else
    b2b(23'h00, 4, 6, "b2b 0..3");
    b2b(23'h0F, 2, 6, "b2b page cross");
`endif

    // cyc dropped during the second cycle of a read
    bus.wb_adr_i = 23'h3F; bus.wb_we_i = 1'b0; bus.wb_sel_i = 2'b11;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    acks = 0; oe_lo = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      end
      if (bus.wb_ack_o) acks++;
      if (!bus.sram_oe_n_o) oe_lo++;
    end
    chk("abort ack count", acks, 0);
    chk("abort oe_n low cycles", oe_lo, 4);
    chk("abort strobes idle", {bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o,
                               bus.sram_lb_n_o, bus.sram_ub_n_o, bus.sram_dat_oe_o}, 6'b111110);
    xfer(vecs[0], 10);

    // reset asserted while WE# is low
    bus.wb_adr_i = 23'h30; bus.wb_dat_i = 16'hAAAA; bus.wb_sel_i = 2'b11;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset we_n", bus.sram_we_n_o, 1'b0);
    res_n = 1'b0;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    chk("mid-write reset strobes", {bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o,
                                    bus.sram_lb_n_o, bus.sram_ub_n_o}, 5'b11111);
    chk("mid-write reset ack", bus.wb_ack_o, 1'b0);
    chk("mid-write reset dat_oe", bus.sram_dat_oe_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid-write reset wb_dat_o", bus.wb_dat_o, 16'h0000);
    chk("mid-write reset sram_adr_o", bus.sram_adr_o, 23'h0);
    res_n = 1'b1;
    @(posedge clk); #1;
    rv = '{1'b0, 23'h22, 16'h0000, 2'b11, 16'h0F0F, 4, 1'b0, 1'b0};
    xfer(rv, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
